// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: ID/EX/MEM pipeline status toward the controller and stall/flush controls back.
// master = pipeline datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rsID;
  logic [4:0]       rtID;
  logic             branchID;
  logic             branchTakenID;
  logic             jumpID;
  logic             memReadEX;
  logic             regWriteEX;
  logic [4:0]       writeRegEX;
  logic             memReadMEM;
  logic [4:0]       writeRegMEM;
  logic             dmemBusy;

  logic             pcWrite;
  logic             ifIdStall;
  logic             ifIdFlush;
  logic             idExFlush;
  logic             idExStall;
  logic             exMemStall;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;
  logic             memTimeout;

  modport master (
    output rsID, rtID, branchID, branchTakenID, jumpID,
           memReadEX, regWriteEX, writeRegEX, memReadMEM, writeRegMEM, dmemBusy,
    input  pcWrite, ifIdStall, ifIdFlush, idExFlush, idExStall, exMemStall,
           stallCycles, flushCount, memTimeout
  );

  modport slave (
    input  rsID, rtID, branchID, branchTakenID, jumpID,
           memReadEX, regWriteEX, writeRegEX, memReadMEM, writeRegMEM, dmemBusy,
    output pcWrite, ifIdStall, ifIdFlush, idExFlush, idExStall, exMemStall,
           stallCycles, flushCount, memTimeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand stalls, redirect flushes, memory-wait freeze.
// Controls are combinational (zero latency) from state + inputs; no backpressure beyond dmemBusy freezing.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, STALL1, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       BUSY_LIM = 8'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [7:0]       r_busy_cnt;
  logic             r_timeout;

  logic       w_load_use;
  logic       w_branch_haz;
  logic       w_redirect;
  logic [7:0] w_busy_inc;
  logic       w_busy_hit;

  logic w_pc_write;
  logic w_if_id_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_id_ex_stall;
  logic w_ex_mem_stall;

  function automatic logic match_x(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt);
    return (r != 5'd0) && ((r == rs) || (r == rt));
  endfunction

  assign w_load_use   = bus.memReadEX && match_x(bus.writeRegEX, bus.rsID, bus.rtID);
  // A load in EX is already covered by load-use, so only ALU producers count here.
  assign w_branch_haz = bus.branchID &&
                        ((bus.regWriteEX && !bus.memReadEX && match_x(bus.writeRegEX, bus.rsID, bus.rtID)) ||
                         (bus.memReadMEM && match_x(bus.writeRegMEM, bus.rsID, bus.rtID)));
  assign w_redirect   = (bus.branchID && bus.branchTakenID) || bus.jumpID;

  assign w_busy_inc = (r_busy_cnt == 8'hFF) ? 8'hFF : r_busy_cnt + 8'd1;
  assign w_busy_hit = bus.dmemBusy && (w_busy_inc == BUSY_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = RUN;
    w_pc_write     = 1'b1;
    w_if_id_stall  = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    if (reset) begin
      w_pc_write    = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (bus.dmemBusy) begin
      w_next         = MEM_WAIT;
      w_pc_write     = 1'b0;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
    end else if (r_state == STALL1) begin
      w_pc_write    = 1'b0;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      // A branch consuming a load needs a second bubble until the load reaches WB.
      w_next        = bus.branchID ? STALL1 : RUN;
      w_pc_write    = 1'b0;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_branch_haz) begin
      w_pc_write    = 1'b0;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_redirect) begin
      w_if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_busy_cnt  <= '0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_if_id_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_if_id_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
      r_busy_cnt <= bus.dmemBusy ? w_busy_inc : 8'd0;
      r_timeout  <= r_timeout | w_busy_hit;
    end
  end

  assign bus.pcWrite     = w_pc_write;
  assign bus.ifIdStall   = w_if_id_stall;
  assign bus.ifIdFlush   = w_if_id_flush;
  assign bus.idExFlush   = w_id_ex_flush;
  assign bus.idExStall   = w_id_ex_stall;
  assign bus.exMemStall  = w_ex_mem_stall;
  assign bus.stallCycles = r_stall_cnt;
  assign bus.flushCount  = r_flush_cnt;
  // Flag is visible in the very cycle the busy run reaches the limit.
  assign bus.memTimeout  = r_timeout | (!reset && w_busy_hit);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector scoreboard bench for pipeline_hazard_ctrl (small counters to reach saturation).
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = '1;

  // ctl = {pcWrite, ifIdStall, ifIdFlush, idExFlush, idExStall, exMemStall}
  localparam logic [5:0] IDLE  = 6'b100000;
  localparam logic [5:0] STALL = 6'b010100;
  localparam logic [5:0] REDIR = 6'b101000;
  localparam logic [5:0] MEMW  = 6'b010011;
  localparam logic [5:0] RST   = 6'b001100;

  typedef struct packed {
    logic       reset;
    logic [4:0] rsID;
    logic [4:0] rtID;
    logic       branchID;
    logic       branchTakenID;
    logic       jumpID;
    logic       memReadEX;
    logic       regWriteEX;
    logic [4:0] writeRegEX;
    logic       memReadMEM;
    logic [4:0] writeRegMEM;
    logic       dmemBusy;
  } in_t;

  typedef struct packed {
    logic [5:0]       ctl;
    logic             mt;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  in_t  vin;
  exp_t exp_q[$];
  string name_q[$];
  logic [CNT_W-1:0] m_sc = '0;
  logic [CNT_W-1:0] m_fc = '0;
  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive();
    reset             = vin.reset;
    bus.rsID          = vin.rsID;
    bus.rtID          = vin.rtID;
    bus.branchID      = vin.branchID;
    bus.branchTakenID = vin.branchTakenID;
    bus.jumpID        = vin.jumpID;
    bus.memReadEX     = vin.memReadEX;
    bus.regWriteEX    = vin.regWriteEX;
    bus.writeRegEX    = vin.writeRegEX;
    bus.memReadMEM    = vin.memReadMEM;
    bus.writeRegMEM   = vin.writeRegMEM;
    bus.dmemBusy      = vin.dmemBusy;
  endtask

  task automatic issue(input string nm, input logic [5:0] ctl, input logic mt);
    exp_t e;
    @(posedge clk);
    #1;
    drive();
    e.ctl = ctl;
    e.mt  = mt;
    e.sc  = m_sc;
    e.fc  = m_fc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (vin.reset) begin
      m_sc = '0;
      m_fc = '0;
    end else begin
      if (ctl[4] && m_sc != CMAX) m_sc = m_sc + 1'b1;
      if (ctl[3] && m_fc != CMAX) m_fc = m_fc + 1'b1;
    end
  endtask

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", nm, what, act, req);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {bus.pcWrite, bus.ifIdStall, bus.ifIdFlush, bus.idExFlush, bus.idExStall, bus.exMemStall};
        chk(nm, "ctl", 32'(act), 32'(e.ctl));
        chk(nm, "memTimeout", 32'(bus.memTimeout), 32'(e.mt));
        chk(nm, "stallCycles", 32'(bus.stallCycles), 32'(e.sc));
        chk(nm, "flushCount", 32'(bus.flushCount), 32'(e.fc));
      end
    end
  end

  initial begin : stim
    vin = '0;
    vin.reset = 1'b1;
    drive();
    repeat (2) @(posedge clk);

    issue("reset", RST, 1'b0);
    vin = '0;
    issue("idle", IDLE, 1'b0);

    vin.memReadEX = 1'b1; vin.writeRegEX = 5'd8; vin.rsID = 5'd8;
    issue("loaduse", STALL, 1'b0);
    vin = '0;
    issue("loaduse_after", IDLE, 1'b0);

    vin.memReadEX = 1'b1;
    issue("reg0", IDLE, 1'b0);

    vin = '0; vin.memReadEX = 1'b1; vin.writeRegEX = 5'd12; vin.rtID = 5'd12;
    issue("loaduse_rt", STALL, 1'b0);

    vin = '0; vin.branchID = 1'b1; vin.branchTakenID = 1'b1; vin.rtID = 5'd9;
    vin.memReadEX = 1'b1; vin.writeRegEX = 5'd9;
    issue("brload_c1", STALL, 1'b0);
    vin.memReadEX = 1'b0; vin.memReadMEM = 1'b1; vin.writeRegMEM = 5'd9;
    issue("brload_c2", STALL, 1'b0);
    vin.memReadMEM = 1'b0;
    issue("brload_c3", REDIR, 1'b0);

    vin = '0; vin.branchID = 1'b1; vin.branchTakenID = 1'b1;
    vin.regWriteEX = 1'b1; vin.writeRegEX = 5'd5; vin.rsID = 5'd5;
    issue("bralu_c1", STALL, 1'b0);
    vin.regWriteEX = 1'b0;
    issue("bralu_c2", REDIR, 1'b0);

    vin = '0; vin.branchID = 1'b1; vin.memReadMEM = 1'b1; vin.writeRegMEM = 5'd7; vin.rsID = 5'd7;
    issue("brmem_c1", STALL, 1'b0);
    vin.memReadMEM = 1'b0;
    issue("brmem_nt", IDLE, 1'b0);

    vin = '0; vin.branchID = 1'b1; vin.regWriteEX = 1'b1;
    issue("bralu_reg0", IDLE, 1'b0);

    vin = '0; vin.jumpID = 1'b1;
    issue("jump", REDIR, 1'b0);

    vin.memReadEX = 1'b1; vin.writeRegEX = 5'd3; vin.rsID = 5'd3;
    issue("jump_lu_c1", STALL, 1'b0);
    vin.memReadEX = 1'b0;
    issue("jump_lu_c2", REDIR, 1'b0);

    vin = '0; vin.dmemBusy = 1'b1; vin.memReadEX = 1'b1; vin.writeRegEX = 5'd4; vin.rsID = 5'd4;
    issue("memw_lu_c1", MEMW, 1'b0);
    vin.dmemBusy = 1'b0;
    issue("memw_lu_c2", STALL, 1'b0);
    vin = '0;
    issue("memw_lu_c3", IDLE, 1'b0);

    for (int k = 0; k < 2; k++) begin
      vin = '0; vin.dmemBusy = 1'b1;
      for (int i = 0; i < 10; i++) issue("busy_short", MEMW, 1'b0);
      vin = '0;
      issue("busy_gap", IDLE, 1'b0);
    end

    vin = '0; vin.dmemBusy = 1'b1; vin.jumpID = 1'b1;
    for (int i = 1; i <= 20; i++) issue("busy_long", MEMW, (i >= 16));
    vin.dmemBusy = 1'b0;
    issue("busy_end_jump", REDIR, 1'b1);
    vin = '0;
    issue("timeout_sticky", IDLE, 1'b1);

    vin = '0; vin.branchID = 1'b1; vin.rtID = 5'd9; vin.memReadEX = 1'b1; vin.writeRegEX = 5'd9;
    issue("rst_stall1_c1", STALL, 1'b1);
    vin = '0; vin.reset = 1'b1;
    issue("rst_stall1_rst", RST, 1'b1);
    vin = '0;
    issue("rst_stall1_after", IDLE, 1'b0);

    vin.dmemBusy = 1'b1;
    issue("rst_memw_c1", MEMW, 1'b0);
    vin = '0; vin.reset = 1'b1;
    issue("rst_memw_rst", RST, 1'b0);
    vin = '0;
    issue("rst_memw_after", IDLE, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never compared", exp_q.size());
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
